mem_access_unit: RTL

Load/store initiator that sits between the datapath and the 32-bit byte-addressed RAM. It accepts one byte, halfword or word request at a time and drives the RAM's write enable, address and write data. It absorbs the RAM's one-cycle registered read latency and sign- or zero-extends loads. Sub-word stores are done as read-modify-write, because the RAM only writes whole 4-byte words.

---
 rtl/mem_access_unit_pkg.sv | 42 ++++
 rtl/mem_access_unit_if.sv | 45 ++++
 rtl/mem_access_unit_lane_align.sv | 58 +++++
 rtl/mem_access_unit.sv | 110 +++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the load/store initiator.
//   size_t        : access width encoding carried on req_size
//   state_t       : FSM states of mem_access_unit
//   is_misaligned : flags accesses the RAM cannot serve (bad alignment or
//                   the reserved size code)
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } state_t;

  // A halfword must sit on an even address, a word on a multiple of four,
  // and the reserved size is always rejected.
  function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the datapath request/response handshake and the RAM port.
//   slave  : view used by mem_access_unit (takes requests, drives the RAM)
//   master : view used by the datapath/RAM side (issues requests, returns
//            ram_rdata)
// Signals:
//   req_valid/req_ready/req_write/req_size/req_signed/req_addr/req_wdata
//   resp_valid/resp_rdata/resp_err
//   ram_we/ram_addr/ram_wdata/ram_rdata
// ---------------------------------------------------------------------------
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for a little-endian 32-bit RAM.
// Ports:
//   i_rdata     : word read from the RAM
//   i_offset    : byte offset addr[1:0] of the access
//   i_size      : access size
//   i_signed    : sign-extend (1) or zero-extend (0) the extracted lane
//   i_newData   : right-justified store data
//   o_extracted : selected lane, extended to 32 bits (load path)
//   o_merged    : i_rdata with the target lane(s) replaced (sub-word store)
// ---------------------------------------------------------------------------
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  size_t       i_size,
  input  logic        i_signed,
  input  logic [31:0] i_newData,
  output logic [31:0] o_extracted,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_shift;

  // Pick the addressed lane out of the read word and widen it to 32 bits.
  // Halfwords only ever live at offset 0 or 2, so offset[1] selects them.
  always_comb begin
    w_shift     = {i_offset, 3'b000};
    w_byte      = i_rdata[w_shift +: 8];
    w_half      = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_extracted = i_rdata;
    case (i_size)
      SZ_BYTE: o_extracted = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
      SZ_HALF: o_extracted = i_signed ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
      default: o_extracted = i_rdata;
    endcase
  end

  // Overlay the new store data onto the old word so the RAM can be written
  // as a whole word while the untouched lanes keep their previous contents.
  always_comb begin
    o_merged = i_rdata;
    case (i_size)
      SZ_BYTE: o_merged[w_shift +: 8] = i_newData[7:0];
      SZ_HALF: begin
        if (i_offset[1]) o_merged[31:16] = i_newData[15:0];
        else             o_merged[15:0]  = i_newData[15:0];
      end
      SZ_WORD: o_merged = i_newData;
      default: o_merged = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store initiator between the datapath and a word-wide RAM with a
// one-cycle registered read. Handles sub-word stores by read-modify-write
// and extends sub-word loads.
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous active-high reset, returns the FSM to idle
//   bus   : mem_access_unit_if.slave (request/response + RAM port)
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  state_t      r_state;
  size_t       r_size;
  logic        r_signed;
  logic [1:0]  r_offset;
  logic [31:0] r_wdata;
  logic [31:0] r_ramAddr;
  logic [31:0] r_respRdata;
  logic        r_respErr;

  size_t       w_reqSize;
  logic        w_accept;
  logic        w_misaligned;
  logic [31:0] w_extracted;
  logic [31:0] w_merged;

  assign w_reqSize    = size_t'(bus.req_size);
  assign w_accept     = bus.req_valid && (r_state == ST_IDLE);
  assign w_misaligned = is_misaligned(w_reqSize, bus.req_addr[1:0]);

  // The same aligner serves the CAP (extract) and RMW_WR (merge) paths;
  // ram_rdata is only meaningful in those two states.
  mem_lane_align u_laneAlign (
    .i_rdata     (bus.ram_rdata),
    .i_offset    (r_offset),
    .i_size      (r_size),
    .i_signed    (r_signed),
    .i_newData   (r_wdata),
    .o_extracted (w_extracted),
    .o_merged    (w_merged)
  );

  // Main FSM. The request is captured on accept; the RAM address is only
  // loaded for accesses that will actually touch the RAM, so an error
  // leaves ram_addr where it was. The response data is cleared on accept so
  // stores and errors report zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_size      <= SZ_BYTE;
      r_signed    <= 1'b0;
      r_offset    <= 2'b00;
      r_wdata     <= '0;
      r_ramAddr   <= '0;
      r_respRdata <= '0;
      r_respErr   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_size      <= w_reqSize;
            r_signed    <= bus.req_signed;
            r_offset    <= bus.req_addr[1:0];
            r_wdata     <= bus.req_wdata;
            r_respRdata <= '0;
            r_respErr   <= w_misaligned;
            if (w_misaligned) begin
              r_state <= ST_RESP;
            end else begin
              r_ramAddr <= {bus.req_addr[31:2], 2'b00};
              if (!bus.req_write)          r_state <= ST_RD;
              else if (w_reqSize == SZ_WORD) r_state <= ST_WR;
              else                           r_state <= ST_RMW_RD;
            end
          end
        end
        ST_RD:     r_state <= ST_CAP;
        ST_CAP: begin
          r_respRdata <= w_extracted;
          r_state     <= ST_RESP;
        end
        ST_WR:     r_state <= ST_RESP;
        ST_RMW_RD: r_state <= ST_RMW_WR;
        ST_RMW_WR: r_state <= ST_RESP;
        ST_RESP:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake and write strobe decode straight from the state register so
  // an asynchronous reset drops ram_we and raises req_ready at once.
  // In RMW_WR the write word is the merge of the word just read back.
  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_rdata = r_respRdata;
  assign bus.resp_err   = r_respErr;
  assign bus.ram_we     = (r_state == ST_WR) || (r_state == ST_RMW_WR);
  assign bus.ram_addr   = r_ramAddr;
  assign bus.ram_wdata  = (r_state == ST_WR)     ? r_wdata  :
                          (r_state == ST_RMW_WR) ? w_merged : '0;

endmodule
